recfg_tile_sched: RTL

Command-driven tile scheduler that sequences the 16×16 reconfigurable systolic array (`recfg_array`).
- Accepts one operation descriptor at a time: mode, number of K tiles, operand-buffer base, tag.
- Per K tile: fetches operands, issues `valid_in` beats, waits for `done_tile`, steers results to the partial-sum or result buffer.
- Returns a tagged completion response.
- Sits between the layer-level controller and the array/operand buffers.

---
 rtl/recfg_pkg.sv | 29 ++
 rtl/recfg_tile_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/recfg_pkg.sv
// Shared definitions for the reconfigurable systolic array scheduler:
// array mode encodings, scheduler state type and mode helpers.
package recfg_pkg;

    localparam logic [2:0] MODE_MAC      = 3'b000;
    localparam logic [2:0] MODE_EWM_MAT  = 3'b001;
    localparam logic [2:0] MODE_EWM_VEC  = 3'b010;
    localparam logic [2:0] MODE_EWM_OUT  = 3'b011;
    localparam logic [2:0] MODE_EWA_VEC  = 3'b100;
    localparam logic [2:0] MODE_EWA_MAT  = 3'b101;
    localparam logic [2:0] MODE_EWM_MAT2 = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_t;

    function automatic logic is_mac(input logic [2:0] mode);
        return mode == MODE_MAC;
    endfunction

    function automatic logic is_legal(input logic [2:0] mode);
        return mode != 3'b111;
    endfunction

endpackage

// File: rtl/recfg_tile_sched.sv
// Tile scheduler sequencing fetch/issue/wait per K tile for recfg_array.
// Optional WAIT watchdog enabled by defining RECFG_SCHED_TIMEOUT_EN.
module recfg_tile_sched
    import recfg_pkg::*;
#(
    parameter int TILE_SIZE   = 16,
    parameter int MAX_KTILES  = 16,
    parameter int ADDR_W      = 8,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 256,
    parameter int KT_W        = $clog2(MAX_KTILES + 1),
    parameter int BEAT_W      = $clog2(TILE_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_mode,
    input  logic [KT_W-1:0]   cmd_ktiles,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              opnd_req,
    output logic [ADDR_W-1:0] opnd_addr,
    input  logic              opnd_ack,
    output logic              arr_valid_in,
    output logic [2:0]        arr_mode,
    output logic              arr_accumulate_en,
    output logic [BEAT_W-1:0] arr_beat,
    input  logic              arr_done_tile,
    output logic              psum_wr,
    output logic              res_wr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy
);

    sched_state_t      state;
    logic [2:0]        mode_q;
    logic [TAG_W-1:0]  tag_q;
    logic [ADDR_W-1:0] base_q;
    logic [KT_W-1:0]   k;
    logic [KT_W-1:0]   klast;
    logic [BEAT_W-1:0] beat;
    logic              err_q;
    logic              illegal;
    logic              in_tile;
    logic              done_ok;
    logic [BEAT_W-1:0] last_beat;

`ifdef RECFG_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;
`endif

    assign illegal = !is_legal(cmd_mode)
                  || (is_mac(cmd_mode) && cmd_ktiles > KT_W'(MAX_KTILES));
    assign last_beat = is_mac(mode_q) ? BEAT_W'(TILE_SIZE - 1) : '0;
    assign in_tile = (state == S_FETCH) || (state == S_ISSUE)
                  || (state == S_WAIT);
    assign done_ok = (state == S_WAIT) && arr_done_tile;

    assign cmd_ready         = (state == S_IDLE);
    assign busy              = (state != S_IDLE);
    assign opnd_req          = (state == S_FETCH);
    assign opnd_addr         = opnd_req ? base_q + ADDR_W'(k) : '0;
    assign arr_valid_in      = (state == S_ISSUE);
    assign arr_beat          = arr_valid_in ? beat : '0;
    assign arr_mode          = mode_q;
    assign arr_accumulate_en = in_tile && (k != '0);
    assign psum_wr           = done_ok && (k != klast);
    assign res_wr            = done_ok && (k == klast);
    assign rsp_valid         = (state == S_RESP);
    assign rsp_tag           = rsp_valid ? tag_q : '0;
    assign rsp_err           = rsp_valid && err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_q <= '0;
            tag_q  <= '0;
            base_q <= '0;
            k      <= '0;
            klast  <= '0;
            beat   <= '0;
            err_q  <= 1'b0;
`ifdef RECFG_SCHED_TIMEOUT_EN
            wd     <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: if (cmd_valid) begin
                    mode_q <= cmd_mode;
                    tag_q  <= cmd_tag;
                    base_q <= cmd_base;
                    k      <= '0;
                    beat   <= '0;
                    // klast holds n_k-1; ktiles of 0 still runs one tile
                    klast  <= (is_mac(cmd_mode) && cmd_ktiles != '0)
                            ? cmd_ktiles - 1'b1 : '0;
                    err_q  <= illegal;
                    state  <= illegal ? S_RESP : S_FETCH;
                end
                S_FETCH: if (opnd_ack) begin
                    beat  <= '0;
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (beat == last_beat) begin
                        state <= S_WAIT;
`ifdef RECFG_SCHED_TIMEOUT_EN
                        wd    <= '0;
`endif
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (arr_done_tile) begin
                        if (k == klast) begin
                            state <= S_RESP;
                        end else begin
                            k     <= k + 1'b1;
                            state <= S_FETCH;
                        end
                    end
`ifdef RECFG_SCHED_TIMEOUT_EN
                    else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                S_RESP: if (rsp_ready) begin
                    mode_q <= '0;
                    err_q  <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
